// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - state encoding, default strobe timing and counter sizing for sram_ctrl
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_HOLD    = 3'd3,
    S_RESP    = 3'd4,
    S_VSETUP  = 3'd5,
    S_VSTROBE = 3'd6,
    S_VHOLD   = 3'd7
  } state_t;

  localparam int T_SETUP_DEF  = 1;
  localparam int T_STROBE_DEF = 2;
  localparam int T_HOLD_DEF   = 1;

  // Counter is loaded with T-1, so clog2(max T) bits suffice; keep at least one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sram_ctrl_timer.sv
// rtl/sram_ctrl_timer.sv - loadable down-counter shared by all timed phases, done when zero
module sram_ctrl_timer #(
  parameter int CW = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_done
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - timed strobe sequencer for the async 8-bit sram with a valid/ready host side
// SRAM_CTRL_VERIFY_EN: writes are followed by a read-back of the same address and a compare.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int T_SETUP  = T_SETUP_DEF,
  parameter int T_STROBE = T_STROBE_DEF,
  parameter int T_HOLD   = T_HOLD_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [AW-1:0] i_req_addr,
  input  logic [DW-1:0] i_req_wdata,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [DW-1:0] o_rsp_rdata,
  output logic          o_rsp_err,
  output logic          o_sram_cs,
  output logic          o_sram_wr,
  output logic          o_sram_rd,
  output logic [AW-1:0] o_sram_addr,
  output logic [DW-1:0] o_sram_din,
  input  logic [DW-1:0] i_sram_dout
);

  localparam int CW = cnt_width(T_SETUP, T_STROBE, T_HOLD);

  state_t        r_state;
  state_t        w_next;
  logic          w_accept;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_done;
  logic          w_cs;
  logic          w_wr;
  logic          w_rd_n;

  logic          r_we;
  logic          r_cs;
  logic          r_wr;
  logic          r_rd_n;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rdata;

  sram_ctrl_timer #(.CW(CW)) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  assign o_req_ready = (r_state == S_IDLE) && i_rst_n;

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid && o_req_ready) begin
          w_accept   = 1'b1;
          w_next     = S_SETUP;
          w_load     = 1'b1;
          w_load_val = CW'(T_SETUP - 1);
        end
      end
      S_SETUP, S_VSETUP: begin
        if (w_done) begin
          w_next     = (r_state == S_SETUP) ? S_STROBE : S_VSTROBE;
          w_load     = 1'b1;
          w_load_val = CW'(T_STROBE - 1);
        end
      end
      S_STROBE, S_VSTROBE: begin
        if (w_done) begin
          w_next     = (r_state == S_STROBE) ? S_HOLD : S_VHOLD;
          w_load     = 1'b1;
          w_load_val = CW'(T_HOLD - 1);
        end
      end
      S_HOLD: begin
        if (w_done) begin
`ifdef SRAM_CTRL_VERIFY_EN
          if (r_we) begin
            w_next     = S_VSETUP;
            w_load     = 1'b1;
            w_load_val = CW'(T_SETUP - 1);
          end else begin
            w_next = S_RESP;
          end
`else
          w_next = S_RESP;
`endif
        end
      end
      S_VHOLD: begin
        if (w_done) w_next = S_RESP;
      end
      S_RESP: begin
        if (i_rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Strobe outputs are registered from the next state so every sram pin changes only on an edge.
  assign w_cs   = w_next inside {S_SETUP, S_STROBE, S_HOLD, S_VSETUP, S_VSTROBE, S_VHOLD};
  assign w_wr   = (w_next == S_STROBE) && r_we;
  assign w_rd_n = !(((w_next == S_STROBE) && !r_we) || (w_next == S_VSTROBE));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_cs        <= 1'b0;
      r_wr        <= 1'b0;
      r_rd_n      <= 1'b1;
      r_addr      <= '0;
      r_din       <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_next;
      r_cs        <= w_cs;
      r_wr        <= w_wr;
      r_rd_n      <= w_rd_n;
      r_rsp_valid <= (w_next == S_RESP);
      if (w_accept) begin
        r_we    <= i_req_we;
        r_addr  <= i_req_addr;
        r_din   <= i_req_wdata;
        r_rdata <= '0;
      end
      // Sample on the edge that ends the strobe, while rd is still asserted.
      if ((r_state == S_STROBE) && w_done && !r_we) r_rdata <= i_sram_dout;
`ifdef SRAM_CTRL_VERIFY_EN
      if ((r_state == S_VSTROBE) && w_done) r_rdata <= i_sram_dout;
`endif
    end
  end

`ifdef SRAM_CTRL_VERIFY_EN
  logic r_err;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if ((r_state == S_VSTROBE) && w_done) begin
      r_err <= (i_sram_dout != r_din);
    end
  end

  assign o_rsp_err = r_err;
`else
  assign o_rsp_err = 1'b0;
`endif

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rdata;
  assign o_sram_cs   = r_cs;
  assign o_sram_wr   = r_wr;
  assign o_sram_rd   = r_rd_n;
  assign o_sram_addr = r_addr;
  assign o_sram_din  = r_din;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - vector table, corner sequences and random traffic against a memory reference
module tb_sram_ctrl;

  localparam int TS = 1;
  localparam int TST = 2;
  localparam int TH = 1;
  localparam int BASE = TS + TST + TH;
`ifdef SRAM_CTRL_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       sram_cs;
  logic       sram_wr;
  logic       sram_rd;
  logic [7:0] sram_addr;
  logic [7:0] sram_din;
  logic [7:0] sram_dout;

  always #5 clk = ~clk;

  sram_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err),
    .o_sram_cs   (sram_cs),
    .o_sram_wr   (sram_wr),
    .o_sram_rd   (sram_rd),
    .o_sram_addr (sram_addr),
    .o_sram_din  (sram_din),
    .i_sram_dout (sram_dout)
  );

  // SRAM model: bit 0 of address 0x10 is stuck at zero.
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  assign sram_dout = mem[sram_addr] & ((sram_addr == 8'h10) ? 8'hFE : 8'hFF);
  always @(posedge clk) if (sram_cs && sram_wr) mem[sram_addr] <= sram_din;

  function automatic logic [7:0] ref_read(input logic [7:0] a);
    return ref_mem[a] & ((a == 8'h10) ? 8'hFE : 8'hFF);
  endfunction

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic       mon_en = 1'b0;
  logic       p_cs = 1'b0;
  logic [7:0] p_addr = '0;
  logic [7:0] p_din = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("wr_rd_overlap", {31'b0, sram_wr && !sram_rd}, 32'd0);
      chk("strobe_without_cs", {31'b0, !sram_cs && (sram_wr || !sram_rd)}, 32'd0);
      if (p_cs && sram_cs) chk("addr_din_stable", {16'b0, sram_addr, sram_din}, {16'b0, p_addr, p_din});
    end
    p_cs   <= sram_cs;
    p_addr <= sram_addr;
    p_din  <= sram_din;
  end

  // Called at a negedge with the controller idle; returns at a negedge with it idle again.
  task automatic txn(input logic we, input logic [7:0] a, input logic [7:0] d, input bit pre_ready,
                     input int stall, output logic [7:0] rdata, output logic err);
    int lat;
    int exp_lat;
    bit w1;
    bit w2;
    logic [7:0] held;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
    if (pre_ready) rsp_ready = 1'b1;
    exp_lat = BASE + 1 + ((we && VER) ? BASE : 0);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
      w1 = (k >= TS + 1) && (k <= TS + TST);
      w2 = (k >= BASE + TS + 1) && (k <= BASE + TS + TST);
      chk("cs_cycle", {31'b0, sram_cs}, {31'b0, k < exp_lat});
      chk("wr_cycle", {31'b0, sram_wr}, {31'b0, we && w1});
      chk("rd_cycle", {31'b0, sram_rd}, {31'b0, !((!we && w1) || (we && VER && w2))});
      chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
    end
    chk("rsp_latency", lat, exp_lat);
    held = rsp_rdata;
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h33; req_wdata = 8'hEE;
      @(negedge clk);
      chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_rdata", {24'b0, rsp_rdata}, {24'b0, held});
      chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rdata = rsp_rdata;
    err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
  endtask

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic er;
    logic [7:0] exp_r;
    logic exp_e;
    logic [7:0] ra;
    logic [7:0] rdat;
    logic rwe;
    logic [7:0] picks [6];

    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'h3C;
      ref_mem[i] = 8'(i) ^ 8'h3C;
    end

    tbl[0] = '{1'b1, 8'hA5, 8'hA2, VER ? 8'hA2 : 8'h00, 1'b0};
    tbl[1] = '{1'b0, 8'hA5, 8'h00, 8'hA2, 1'b0};
    tbl[2] = '{1'b0, 8'h5A, 8'h00, 8'h66, 1'b0};
    tbl[3] = '{1'b1, 8'h10, 8'hFF, VER ? 8'hFE : 8'h00, VER};
    tbl[4] = '{1'b0, 8'h10, 8'h00, 8'hFE, 1'b0};
    tbl[5] = '{1'b1, 8'h20, 8'h5A, VER ? 8'h5A : 8'h00, 1'b0};
    tbl[6] = '{1'b0, 8'h20, 8'h00, 8'h5A, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 8'h00, 8'h3C, 1'b0};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", {31'b0, sram_cs}, 32'd0);
    chk("rst_wr", {31'b0, sram_wr}, 32'd0);
    chk("rst_rd", {31'b0, sram_rd}, 32'd1);
    chk("rst_addr", {24'b0, sram_addr}, 32'd0);
    chk("rst_din", {24'b0, sram_din}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", {24'b0, rsp_rdata}, 32'd0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready_after_rst", {31'b0, req_ready}, 32'd1);
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0, 0, rd, er);
      if (tbl[i].we) ref_mem[tbl[i].addr] = tbl[i].wdata;
      chk($sformatf("tbl%0d_rdata", i), {24'b0, rd}, {24'b0, tbl[i].exp_rdata});
      chk($sformatf("tbl%0d_err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
    end

    // Response stalled three cycles with a competing request that must be ignored.
    txn(1'b0, 8'hA5, 8'h00, 1'b0, 3, rd, er);
    chk("stall_final_rdata", {24'b0, rd}, 32'hA2);
    txn(1'b0, 8'h33, 8'h00, 1'b0, 0, rd, er);
    chk("ignored_req_no_write", {24'b0, rd}, {24'b0, ref_read(8'h33)});

    // Reset during the read strobe.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h42;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_strobe", {31'b0, sram_rd}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_cs", {31'b0, sram_cs}, 32'd0);
    chk("abort_wr", {31'b0, sram_wr}, 32'd0);
    chk("abort_rd", {31'b0, sram_rd}, 32'd1);
    chk("abort_addr", {24'b0, sram_addr}, 32'd0);
    chk("abort_din", {24'b0, sram_din}, 32'd0);
    chk("abort_req_ready", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
    end

    picks[0] = 8'hA5; picks[1] = 8'h10; picks[2] = 8'h20;
    picks[3] = 8'h33; picks[4] = 8'h77; picks[5] = 8'hC3;
    for (int i = 0; i < 40; i++) begin
      rwe  = 1'($urandom);
      ra   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : picks[$urandom_range(0, 5)];
      rdat = 8'($urandom);
      if (rwe) begin
        ref_mem[ra] = rdat;
        exp_r = VER ? ref_read(ra) : 8'h00;
        exp_e = VER && (ref_read(ra) != rdat);
      end else begin
        exp_r = ref_read(ra);
        exp_e = 1'b0;
      end
      txn(rwe, ra, rdat, 1'($urandom), 0, rd, er);
      chk("rand_rdata", {24'b0, rd}, {24'b0, exp_r});
      chk("rand_err", {31'b0, er}, {31'b0, exp_e});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
